// File: rtl/ctrl_pkg.sv
// rtl/ctrl_pkg.sv - opcode, state and datapath select codes shared by the multicycle control FSM
package ctrl_pkg;

    localparam logic [3:0] OP_RTYPE = 4'h0;
    localparam logic [3:0] OP_LW    = 4'h1;
    localparam logic [3:0] OP_SW    = 4'h2;
    localparam logic [3:0] OP_BEQ   = 4'h3;
    localparam logic [3:0] OP_J     = 4'h4;
    localparam logic [3:0] OP_ADDI  = 4'h5;
    localparam logic [3:0] OP_HALT  = 4'hF;

    typedef enum logic [3:0] {
        ST_RST_IDLE = 4'd0,
        ST_FETCH    = 4'd1,
        ST_DECODE   = 4'd2,
        ST_EXEC     = 4'd3,
        ST_RWB      = 4'd4,
        ST_ADDR     = 4'd5,
        ST_MREAD    = 4'd6,
        ST_MWB      = 4'd7,
        ST_MWRITE   = 4'd8,
        ST_IWB      = 4'd9,
        ST_BRANCH   = 4'd10,
        ST_JUMP     = 4'd11,
        ST_HALT     = 4'd12
    } state_e;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    localparam logic [1:0] SELB_RD2 = 2'b00;
    localparam logic [1:0] SELB_ONE = 2'b01;
    localparam logic [1:0] SELB_IMM = 2'b10;

    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_IMM    = 2'b10;

    function automatic logic is_legal_op(input logic [3:0] op);
        case (op)
            OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_J, OP_ADDI, OP_HALT: is_legal_op = 1'b1;
            default:                                                is_legal_op = 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/multicycle_ctrl.sv
// rtl/multicycle_ctrl.sv - multicycle control FSM sequencing fetch/decode/execute/memory/write-back
module multicycle_ctrl
    import ctrl_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] Opcode,
    input  logic       Zero,
    input  logic       mem_ack,
    output logic       mem_req,
    output logic       MemWrite,
    output logic       IorD,
    output logic       IRWrite,
    output logic       PCWrite,
    output logic       PCWriteCond,
    output logic [1:0] PCSource,
    output logic       ALUSelA,
    output logic [1:0] ALUSelB,
    output logic [1:0] ALUOp,
    output logic       RegWrite,
    output logic       RegDst,
    output logic       MemtoReg,
    output logic       instr_done,
    output logic       halted,
    output logic       illegal
);

    state_e state_q, state_d;
    logic   illegal_q, illegal_d;

    // Zero gates the PC in the datapath; the controller only raises PCWriteCond.
    logic unused_zero;
    assign unused_zero = Zero;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_RST_IDLE;
            illegal_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            illegal_q <= illegal_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        illegal_d   = illegal_q;
        mem_req     = 1'b0;
        MemWrite    = 1'b0;
        IorD        = 1'b0;
        IRWrite     = 1'b0;
        PCWrite     = 1'b0;
        PCWriteCond = 1'b0;
        PCSource    = PCSRC_ALU;
        ALUSelA     = 1'b0;
        ALUSelB     = SELB_RD2;
        ALUOp       = ALUOP_ADD;
        RegWrite    = 1'b0;
        RegDst      = 1'b0;
        MemtoReg    = 1'b0;
        instr_done  = 1'b0;
        halted      = 1'b0;
        illegal     = illegal_q;

        case (state_q)
            ST_RST_IDLE: state_d = ST_FETCH;
            ST_FETCH: begin
                mem_req = 1'b1;
                ALUSelB = SELB_ONE;
                IRWrite = mem_ack;
                PCWrite = mem_ack;
                if (mem_ack) state_d = ST_DECODE;
            end
            ST_DECODE: begin
                ALUSelB = SELB_IMM;
                case (Opcode)
                    OP_RTYPE:              state_d = ST_EXEC;
                    OP_LW, OP_SW, OP_ADDI: state_d = ST_ADDR;
                    OP_BEQ:                state_d = ST_BRANCH;
                    OP_J:                  state_d = ST_JUMP;
                    default:               state_d = ST_HALT;
                endcase
                if (!is_legal_op(Opcode)) illegal_d = 1'b1;
            end
            ST_EXEC: begin
                ALUSelA = 1'b1;
                ALUOp   = ALUOP_FUNCT;
                state_d = ST_RWB;
            end
            ST_RWB: begin
                RegDst     = 1'b1;
                RegWrite   = 1'b1;
                instr_done = 1'b1;
                state_d    = ST_FETCH;
            end
            ST_ADDR: begin
                ALUSelA = 1'b1;
                ALUSelB = SELB_IMM;
                case (Opcode)
                    OP_LW:   state_d = ST_MREAD;
                    OP_SW:   state_d = ST_MWRITE;
                    default: state_d = ST_IWB;
                endcase
            end
            ST_MREAD: begin
                mem_req = 1'b1;
                IorD    = 1'b1;
                if (mem_ack) state_d = ST_MWB;
            end
            ST_MWB: begin
                MemtoReg   = 1'b1;
                RegWrite   = 1'b1;
                instr_done = 1'b1;
                state_d    = ST_FETCH;
            end
            ST_MWRITE: begin
                mem_req    = 1'b1;
                MemWrite   = 1'b1;
                IorD       = 1'b1;
                instr_done = mem_ack;
                if (mem_ack) state_d = ST_FETCH;
            end
            ST_IWB: begin
                RegWrite   = 1'b1;
                instr_done = 1'b1;
                state_d    = ST_FETCH;
            end
            ST_BRANCH: begin
                ALUSelA     = 1'b1;
                ALUOp       = ALUOP_SUB;
                PCWriteCond = 1'b1;
                PCSource    = PCSRC_ALUOUT;
                instr_done  = 1'b1;
                state_d     = ST_FETCH;
            end
            ST_JUMP: begin
                PCWrite    = 1'b1;
                PCSource   = PCSRC_IMM;
                instr_done = 1'b1;
                state_d    = ST_FETCH;
            end
            ST_HALT: halted = 1'b1;
            default: state_d = ST_RST_IDLE;
        endcase
    end

endmodule

// File: tb/tb_multicycle_ctrl.sv
// tb/tb_multicycle_ctrl.sv - randomized self-checking bench for multicycle_ctrl
module tb_multicycle_ctrl;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [3:0] Opcode = 4'h0;
    logic       Zero = 1'b0;
    logic       mem_ack = 1'b0;
    logic       mem_req, MemWrite, IorD, IRWrite, PCWrite, PCWriteCond;
    logic [1:0] PCSource, ALUSelB, ALUOp;
    logic       ALUSelA, RegWrite, RegDst, MemtoReg, instr_done, halted, illegal;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    multicycle_ctrl dut (
        .clk(clk), .rst_n(rst_n), .Opcode(Opcode), .Zero(Zero), .mem_ack(mem_ack),
        .mem_req(mem_req), .MemWrite(MemWrite), .IorD(IorD), .IRWrite(IRWrite),
        .PCWrite(PCWrite), .PCWriteCond(PCWriteCond), .PCSource(PCSource),
        .ALUSelA(ALUSelA), .ALUSelB(ALUSelB), .ALUOp(ALUOp), .RegWrite(RegWrite),
        .RegDst(RegDst), .MemtoReg(MemtoReg), .instr_done(instr_done),
        .halted(halted), .illegal(illegal)
    );

    logic [18:0] outv;
    assign outv = {mem_req, MemWrite, IorD, IRWrite, PCWrite, PCWriteCond, PCSource,
                   ALUSelA, ALUSelB, ALUOp, RegWrite, RegDst, MemtoReg,
                   instr_done, halted, illegal};

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    endtask

    function automatic logic [18:0] ov(input logic mr, mw, iord, irw, pcw, pcwc,
                                       input logic [1:0] pcs, input logic asa,
                                       input logic [1:0] asb, aop,
                                       input logic rw, rd, m2r, dn, hlt, ill);
        return {mr, mw, iord, irw, pcw, pcwc, pcs, asa, asb, aop, rw, rd, m2r, dn, hlt, ill};
    endfunction

    // Expected control words per instruction phase, taken from the state table.
    localparam logic [18:0] V_ZERO   = 19'd0;
    logic [18:0] v_fetch_w, v_fetch_a, v_decode, v_exec, v_rwb, v_addr, v_mread, v_mwb;
    logic [18:0] v_mwrite_w, v_mwrite_a, v_iwb, v_branch, v_jump, v_halt, v_halt_ill;

    initial begin
        v_fetch_w  = ov(1,0,0,0,0,0,2'b00,0,2'b01,2'b00,0,0,0,0,0,0);
        v_fetch_a  = ov(1,0,0,1,1,0,2'b00,0,2'b01,2'b00,0,0,0,0,0,0);
        v_decode   = ov(0,0,0,0,0,0,2'b00,0,2'b10,2'b00,0,0,0,0,0,0);
        v_exec     = ov(0,0,0,0,0,0,2'b00,1,2'b00,2'b10,0,0,0,0,0,0);
        v_rwb      = ov(0,0,0,0,0,0,2'b00,0,2'b00,2'b00,1,1,0,1,0,0);
        v_addr     = ov(0,0,0,0,0,0,2'b00,1,2'b10,2'b00,0,0,0,0,0,0);
        v_mread    = ov(1,0,1,0,0,0,2'b00,0,2'b00,2'b00,0,0,0,0,0,0);
        v_mwb      = ov(0,0,0,0,0,0,2'b00,0,2'b00,2'b00,1,0,1,1,0,0);
        v_mwrite_w = ov(1,1,1,0,0,0,2'b00,0,2'b00,2'b00,0,0,0,0,0,0);
        v_mwrite_a = ov(1,1,1,0,0,0,2'b00,0,2'b00,2'b00,0,0,0,1,0,0);
        v_iwb      = ov(0,0,0,0,0,0,2'b00,0,2'b00,2'b00,1,0,0,1,0,0);
        v_branch   = ov(0,0,0,0,0,1,2'b01,1,2'b00,2'b01,0,0,0,1,0,0);
        v_jump     = ov(0,0,0,0,1,0,2'b10,0,2'b00,2'b00,0,0,0,1,0,0);
        v_halt     = ov(0,0,0,0,0,0,2'b00,0,2'b00,2'b00,0,0,0,0,1,0);
        v_halt_ill = ov(0,0,0,0,0,0,2'b00,0,2'b00,2'b00,0,0,0,0,1,1);
    end

    // Called just after a rising edge; drives ack, checks at the falling edge, returns after next edge.
    task automatic step(input logic ack, input logic [18:0] exp, input string tag, output logic dn);
        mem_ack = ack;
        Zero    = 1'($urandom);
        @(negedge clk);
        check_eq(tag, 32'(outv), 32'(exp));
        dn = instr_done;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        logic [18:0] zexp;
        zexp  = V_ZERO;
        rst_n = 1'b0;
        #1;
        check_eq("rst_async", 32'(outv), 32'(zexp));
        mem_ack = 1'b1;
        @(posedge clk);
        @(posedge clk);
        #1;
        check_eq("rst_held", 32'(outv), 32'(zexp));
        mem_ack = 1'b0;
        rst_n   = 1'b1;
        @(negedge clk);
        check_eq("rst_idle", 32'(outv), 32'(zexp));
        @(posedge clk);
        #1;
    endtask

    function automatic int base_cycles(input logic [3:0] op);
        case (op)
            4'h3, 4'h4:       return 3;
            4'h0, 4'h5, 4'h2: return 4;
            default:          return 5;
        endcase
    endfunction

    // Runs one legal non-halt instruction starting in its first FETCH cycle.
    task automatic run_instr(input logic [3:0] op, input int fw, input int mw);
        int   cyc, first_done, n_done;
        logic dn;
        cyc = 0; first_done = 0; n_done = 0;
        for (int i = 0; i < fw; i++) begin
            Opcode = 4'($urandom);
            step(1'b0, v_fetch_w, "fetch_wait", dn);
            cyc++; if (dn) begin n_done++; if (first_done == 0) first_done = cyc; end
        end
        step(1'b1, v_fetch_a, "fetch_ack", dn);
        cyc++; if (dn) begin n_done++; if (first_done == 0) first_done = cyc; end
        Opcode = op;
        step(1'($urandom), v_decode, "decode", dn);
        cyc++; if (dn) begin n_done++; if (first_done == 0) first_done = cyc; end
        case (op)
            4'h0: begin
                step(1'($urandom), v_exec, "exec", dn);
                cyc++; if (dn) begin n_done++; if (first_done == 0) first_done = cyc; end
                step(1'($urandom), v_rwb, "rwb", dn);
                cyc++; if (dn) begin n_done++; if (first_done == 0) first_done = cyc; end
            end
            4'h3: begin
                step(1'($urandom), v_branch, "branch", dn);
                cyc++; if (dn) begin n_done++; if (first_done == 0) first_done = cyc; end
            end
            4'h4: begin
                step(1'($urandom), v_jump, "jump", dn);
                cyc++; if (dn) begin n_done++; if (first_done == 0) first_done = cyc; end
            end
            default: begin
                step(1'($urandom), v_addr, "addr", dn);
                cyc++; if (dn) begin n_done++; if (first_done == 0) first_done = cyc; end
                if (op == 4'h5) begin
                    step(1'($urandom), v_iwb, "iwb", dn);
                    cyc++; if (dn) begin n_done++; if (first_done == 0) first_done = cyc; end
                end else begin
                    for (int i = 0; i < mw; i++) begin
                        step(1'b0, (op == 4'h1) ? v_mread : v_mwrite_w, "mem_wait", dn);
                        cyc++; if (dn) begin n_done++; if (first_done == 0) first_done = cyc; end
                    end
                    step(1'b1, (op == 4'h1) ? v_mread : v_mwrite_a, "mem_ack", dn);
                    cyc++; if (dn) begin n_done++; if (first_done == 0) first_done = cyc; end
                    if (op == 4'h1) begin
                        step(1'($urandom), v_mwb, "mwb", dn);
                        cyc++; if (dn) begin n_done++; if (first_done == 0) first_done = cyc; end
                    end
                end
            end
        endcase
        check_eq("done_count", 32'(n_done), 32'd1);
        check_eq("cpi", 32'(first_done),
                 32'(base_cycles(op) + fw + ((op == 4'h1 || op == 4'h2) ? mw : 0)));
    endtask

    task automatic run_halt(input logic [3:0] op, input int fw);
        logic        dn;
        logic [18:0] hexp;
        hexp = (op == 4'hF) ? v_halt : v_halt_ill;
        for (int i = 0; i < fw; i++) step(1'b0, v_fetch_w, "fetch_wait", dn);
        step(1'b1, v_fetch_a, "fetch_ack", dn);
        Opcode = op;
        step(1'($urandom), v_decode, "decode", dn);
        for (int i = 0; i < 4; i++) begin
            Opcode = 4'($urandom);
            step(1'($urandom), hexp, "halt", dn);
        end
        do_reset();
    endtask

    initial begin
        logic        dn;
        logic [3:0]  op;
        logic [3:0]  legal_ops [6];
        legal_ops = '{4'h0, 4'h1, 4'h2, 4'h3, 4'h4, 4'h5};

        @(posedge clk);
        #1;
        do_reset();

        // Reset while a fetch request is outstanding.
        step(1'b0, v_fetch_w, "fetch_wait", dn);
        @(negedge clk);
        check_eq("pre_rst_req", 32'(mem_req), 32'd1);
        #2;
        do_reset();
        check_eq("req_after_rst", 32'({mem_req, IorD}), 32'b10);

        run_instr(4'h5, 0, 0);
        run_instr(4'h1, 3, 2);
        run_instr(4'h3, 0, 0);
        run_instr(4'h4, 0, 0);
        run_instr(4'h2, 1, 2);
        run_instr(4'h0, 0, 0);
        run_halt(4'h9, 0);
        run_halt(4'hF, 1);

        for (int n = 0; n < 60; n++) begin
            if ($urandom_range(0, 9) == 0) begin
                op = 4'($urandom_range(6, 15));
                run_halt(op, $urandom_range(0, 3));
            end else begin
                op = legal_ops[$urandom_range(0, 5)];
                run_instr(op, $urandom_range(0, 3), $urandom_range(0, 3));
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/multicycle_ctrl.md
# multicycle_ctrl

Multicycle control FSM for the 8-bit datapath: sequences the ALU, instruction register, register file, PC and memory port across fetch, decode, execute, memory and write-back. It sits beside the ALU and drives its operand selects (ALUSelA, ALUSelB) and operation class (ALUOp). It also consumes the ALU's Zero flag for branches. Memory is reached through a req/ack handshake, so any state that touches memory may stall for an arbitrary number of cycles.

## Interface
- No parameters; opcode and state encodings live in the shared package.
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous, active-low reset
- Opcode  in  4  Instruction[15:12], valid from the IR after FETCH
- Zero  in  1  ALU zero flag
- mem_ack  in  1  memory completes the current request this cycle
- mem_req  out  1  memory request; held high until mem_ack
- MemWrite  out  1  request is a write (valid only while mem_req)
- IorD  out  1  0: address = PC, 1: address = ALUOut
- IRWrite  out  1  load IR
- PCWrite  out  1  unconditional PC load
- PCWriteCond  out  1  PC load when Zero
- PCSource  out  2  00: ALU result, 01: ALUOut, 10: Instruction[7:0]
- ALUSelA  out  1  0: PC, 1: ReadData1
- ALUSelB  out  2  00: ReadData2, 01: constant 1, 10: Instruction[7:0]
- ALUOp  out  2  00: add, 01: sub, 10: funct-decoded
- RegWrite, RegDst, MemtoReg  out  1 each  register-file write controls
- instr_done  out  1  one-cycle pulse on the last cycle of each instruction
- halted  out  1  core stopped; illegal  out  1  stop was caused by an undefined opcode

## Operation
- Opcodes:
  - 0 RTYPE, 1 LW, 2 SW, 3 BEQ, 4 J, 5 ADDI, F HALT.
  - Every other opcode is illegal.
- States and transitions:
  - RST_IDLE → FETCH.
  - FETCH: mem_req=1, IorD=0, ALUSelA=0, ALUSelB=01, ALUOp=00, PCSource=00. IRWrite and PCWrite are asserted only in the cycle where mem_ack=1; stay in FETCH until then, then → DECODE.
  - DECODE: ALUSelA=0, ALUSelB=10, ALUOp=00 (branch target into ALUOut). Then branch on Opcode:
    - RTYPE → EXEC
    - LW/SW/ADDI → ADDR
    - BEQ → BRANCH
    - J → JUMP
    - HALT → HALT
    - illegal → HALT with illegal=1
  - EXEC: ALUSelA=1, ALUSelB=00, ALUOp=10 → RWB.
  - RWB: RegDst=1, MemtoReg=0, RegWrite=1, instr_done → FETCH.
  - ADDR: ALUSelA=1, ALUSelB=10, ALUOp=00. Then LW → MREAD, SW → MWRITE, ADDI → IWB.
  - MREAD: mem_req=1, IorD=1; wait for mem_ack → MWB.
  - MWB: RegDst=0, MemtoReg=1, RegWrite=1, instr_done → FETCH.
  - MWRITE: mem_req=1, MemWrite=1, IorD=1; on mem_ack assert instr_done → FETCH.
  - IWB: RegDst=0, MemtoReg=0, RegWrite=1, instr_done → FETCH.
  - BRANCH: ALUSelA=1, ALUSelB=00, ALUOp=01, PCWriteCond=1, PCSource=01, instr_done → FETCH.
  - JUMP: PCWrite=1, PCSource=10, instr_done → FETCH.
  - HALT: halted=1, all enables 0. Terminal until rst_n.
- Any output not listed for a state is 0.
- The FSM never reads Zero directly; PC update gating on Zero belongs to the datapath.

## Timing
- Outputs are a combinational decode of the state register, except IRWrite, PCWrite (FETCH) and instr_done (MWRITE), which are additionally qualified by mem_ack.
- Reset: state=RST_IDLE, illegal flag cleared; every output 0 while rst_n=0 and during the first cycle after release.
- mem_req rises in the first cycle of FETCH, MREAD or MWRITE. It stays high, with address/write controls stable, until the mem_ack cycle, and drops on the next edge as the state changes.
- mem_ack outside a memory state is ignored.
- Minimum cycles per instruction, with ack in the first cycle:
  - J, BEQ: 3
  - RTYPE, ADDI, SW: 4
  - LW: 5
- Each memory wait cycle adds 1.
- Reset asserted mid-instruction: outputs drop to 0 immediately (asynchronous). No partial write is reissued; fetch restarts from the current PC.

## Structure
- Package ctrl_pkg holds:
  - opcode localparams
  - the state enum, binary-encoded in 4 bits
  - ALUOp, ALUSelB and PCSource codes, shared with the ALU and datapath
- Single module, no submodules; one sequential process for state/illegal and one combinational decode process.

## Test plan
- Reset mid-FETCH with mem_req=1 → mem_req=0 at once; two cycles after rst_n rises, mem_req=1 with IorD=0.
- ADDI with mem_ack on the first request → states FETCH, DECODE, ADDR, IWB; RegWrite=1, RegDst=0 in cycle 4; instr_done exactly once.
- LW with a fetch ack delayed 3 cycles and a read ack delayed 2 → IRWrite/PCWrite high in exactly one cycle; 5+3+2=10 cycles to instr_done; MemtoReg=1 in MWB.
- BEQ → BRANCH shows ALUOp=01, PCWriteCond=1, PCSource=01; J → PCWrite=1, PCSource=10; each takes 3 cycles.
- SW → MemWrite=1 only while mem_req=1 and IorD=1; instr_done on the ack cycle; RegWrite never asserted.
- Opcode 0x9 → HALT with halted=1, illegal=1, mem_req=0 permanently; opcode 0xF → halted=1, illegal=0.
